// File: rtl/mul_unit_seq.sv
// Sequential shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// One add-and-shift per cycle on operand magnitudes; the sign is applied once at the end.
module mul_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       State_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         f3;
  logic [WIDTH-1:0]   mcand, mplr;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   result_q;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   word_sel;

  // Operand preparation from the live inputs; only consumed on the start edge.
  // MUL is treated as signed because its low word does not depend on signedness.
  always_comb begin
    neg_a = SrcA[WIDTH-1] && (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010);
    neg_b = SrcB[WIDTH-1] && (Funct3 == 3'b000 || Funct3 == 3'b001);
    abs_a = neg_a ? -SrcA : SrcA;
    abs_b = neg_b ? -SrcB : SrcB;
  end

  assign sum         = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
  assign prod_signed = neg ? -prod : prod;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word_sel = '0;
    case (f3)
      3'b000:                 word_sel = prod_signed[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: word_sel = prod_signed[2*WIDTH-1:WIDTH];
      default:                word_sel = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      f3       <= '0;
      mcand    <= '0;
      mplr     <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (Start) begin
          f3    <= Funct3;
          mcand <= abs_a;
          mplr  <= abs_b;
          neg   <= neg_a ^ neg_b;
          prod  <= '0;
          cnt   <= '0;
        end
        CALC: begin
          // Shift {carry, product} right, bringing the adder carry into the top bit.
          prod <= {sum, prod[WIDTH-1:1]};
          mplr <= mplr >> 1;
          cnt  <= cnt + CW'(1);
        end
        SIGN: result_q <= word_sel;
        default: ;
      endcase
    end
  end

  assign Result  = result_q;
  assign Busy    = (state == CALC) || (state == SIGN);
  assign Done    = (state == DONE);
  assign State_o = state;

endmodule

// File: doc/mul_unit_seq.md
# mul_unit_seq

Sequential RV32M multiplier for the multicycle datapath. It sits directly downstream of the control unit's register-execute step: the control unit pulses `Start` with the R-type operands and `Funct3`, holds in its execute state while `Busy` is high, and writes `Result` back on `Done`. It uses one shift-add iteration per cycle, so it needs a single adder and no hard multiplier.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. The iteration counter is `$clog2(WIDTH)` bits wide.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `Start`  in  1: request; sampled only in IDLE.
- `Funct3`  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx unsupported.
- `SrcA`  in  WIDTH: rs1 operand; sampled with `Start`.
- `SrcB`  in  WIDTH: rs2 operand; sampled with `Start`.
- `Result`  out  WIDTH: registered result; held until the next op completes.
- `Busy`  out  1: high in CALC and SIGN.
- `Done`  out  1: one-cycle pulse in DONE.
- `State_o`  out  2: debug state; IDLE=0, CALC=1, SIGN=2, DONE=3.

## Operation
Reset:
- State goes to IDLE.
- `Result`=0, `Busy`=0, `Done`=0, counter=0.
- Product, multiplicand and multiplier registers are cleared.

Signedness, from the `Funct3` latched at start:
- SrcA is signed for MUL, MULH and MULHSU.
- SrcB is signed for MUL and MULH.
- MULHU treats both operands as unsigned.
- For MUL the low word is identical for either signedness, so MUL is treated as signed.

IDLE:
- If `Start`=1, latch `Funct3`.
- Latch the magnitudes |SrcA| and |SrcB|, using the two's-complement absolute value for signed operands.
- Latch the negate flag = signA XOR signB.
- Clear the 2*WIDTH product and the counter, then go to CALC.
- If `Start`=0, stay in IDLE.

CALC (one iteration per cycle):
- If multiplier bit 0 = 1, add the multiplicand into product[2W-1:W] as a (W+1)-bit sum.
- Shift {carry, product} right by 1 and shift the multiplier right by 1.
- Counter +1. After the iteration with counter = WIDTH-1, go to SIGN.

SIGN:
- If the negate flag is set, two's-complement the full 2*WIDTH product.
- Select the output word:
  - MUL: low word.
  - MULH, MULHSU, MULHU: high word.
  - 1xx: 0.
- Load the selected word into `Result`, then go to DONE.

DONE:
- `Done`=1 for exactly this one cycle, then go to IDLE.
- `Start` is ignored in DONE.

Edge behaviour:
- `Start` while `Busy`=1 or in DONE is ignored; no re-latch and no restart.
- Operand or `Funct3` changes after the start edge have no effect.
- The most-negative operand (0x80000000) has magnitude 0x80000000, which is correct as unsigned; no overflow special case is needed.
- Async reset mid-operation aborts immediately with all outputs at their reset values; the partial result is never published.

## Timing
- Start edge E (IDLE, `Start`=1):
  - Cycles E+1 .. E+WIDTH: CALC.
  - Cycle E+WIDTH+1: SIGN.
  - Cycle E+WIDTH+2: DONE.
- With WIDTH=32, `Done` is high in the cycle 34 edges after the start edge.
- `Busy` rises the cycle after the start edge and falls when DONE is entered.
- `Result` updates at the edge entering DONE and is stable while `Done` is high and after it drops.
- The earliest accepted restart is the first IDLE cycle after DONE, so back-to-back throughput is one op per WIDTH+3 cycles.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Test plan
- MUL: SrcA=7, SrcB=6 -> `Done` exactly 34 cycles after the start edge, `Result`=0x0000002A, `Busy` high for exactly 33 cycles.
- MULH: SrcA=0xFFFFFFFD (-3), SrcB=5 -> `Result`=0xFFFFFFFF. Also SrcA=SrcB=0x80000000 -> `Result`=0x40000000.
- MULHU: SrcA=SrcB=0xFFFFFFFF -> `Result`=0xFFFFFFFE. MUL on the same operands -> `Result`=0x00000001.
- MULHSU: SrcA=0xFFFFFFFF (-1), SrcB=0xFFFFFFFF (unsigned) -> `Result`=0xFFFFFFFF.
- Start MUL 3*4, then pulse `Start` with 9*9 at cycle 10 and in the DONE cycle -> only one `Done`, `Result`=12, `State_o` returns to 0.
- Start MULHU, assert `rst`=0 at cycle 15 -> State IDLE immediately, `Result`=0, `Busy`=0, `Done`=0. A subsequent MUL 5*5 -> `Result`=25. Funct3=100 -> `Result`=0 after full latency.
